apb_clk_en_div_multi: RTL and testbench

//  Multi-channel programmable clock-enable generator for the SoC APB/peripheral side of the bridge.

---
 rtl/apb_clk_en_div_multi_if.sv | 25 ++
 rtl/apb_clk_en_div_multi.sv | 98 +++++++++
 tb/tb_apb_clk_en_div_multi.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/apb_clk_en_div_multi_if.sv
// Bus bundle for the multi-channel clock-enable divider: factor requests,
// alignment and enables in; acks, active factors and divided outputs out.
interface apb_clk_en_div_multi_if #(
  parameter int unsigned DIV_WID = 4,
  parameter int unsigned CH_NUM  = 4
);
  logic [CH_NUM-1:0]         ch_en;
  logic [CH_NUM*DIV_WID-1:0] div_factor;
  logic [CH_NUM-1:0]         div_upd;
  logic                      align;
  logic [CH_NUM-1:0]         div_ack;
  logic [CH_NUM*DIV_WID-1:0] div_cur;
  logic [CH_NUM-1:0]         clk_en;
  logic [CH_NUM-1:0]         clk_div;

  modport master (
    output ch_en, div_factor, div_upd, align,
    input  div_ack, div_cur, clk_en, clk_div
  );

  modport slave (
    input  ch_en, div_factor, div_upd, align,
    output div_ack, div_cur, clk_en, clk_div
  );
endinterface

// File: rtl/apb_clk_en_div_multi.sv
// Multi-channel programmable hclk clock-enable generator with per-channel
// runtime divide factors, period-boundary factor update with ack, and global align.
module apb_clk_en_div_multi #(
  parameter int unsigned DIV_WID = 4,
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  apb_clk_en_div_multi_if.slave bus
);

  localparam logic [DIV_WID-1:0] DEF_F = DIV_WID'(DEF_DIV);
  localparam logic [DIV_WID-1:0] ONE_F = DIV_WID'(1);

  logic [DIV_WID-1:0] cnt_q    [CH_NUM];
  logic [DIV_WID-1:0] cur_q    [CH_NUM];
  logic [DIV_WID-1:0] shadow_q [CH_NUM];
  logic [CH_NUM-1:0]  pend_q;
  logic [CH_NUM-1:0]  en_q;
  logic [CH_NUM-1:0]  div_q;
  logic [CH_NUM-1:0]  ack_q;

  logic [DIV_WID-1:0] n_eff     [CH_NUM];
  logic [DIV_WID:0]   half      [CH_NUM];
  logic [DIV_WID-1:0] cnt_nx    [CH_NUM];
  logic [DIV_WID-1:0] shadow_nx [CH_NUM];
  logic [CH_NUM-1:0]  wrap;
  logic [CH_NUM-1:0]  apply;
  logic [CH_NUM-1:0]  lvl_nx;
  logic [CH_NUM*DIV_WID-1:0] cur_flat;

  // A div_upd arriving on the apply edge is folded in directly, so the
  // request seen that cycle is the value that takes effect.
  always_comb begin
    n_eff     = '{default: '0};
    half      = '{default: '0};
    cnt_nx    = '{default: '0};
    shadow_nx = '{default: '0};
    wrap      = '0;
    apply     = '0;
    lvl_nx    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      n_eff[i]     = (cur_q[i] == '0) ? ONE_F : cur_q[i];
      half[i]      = ({1'b0, n_eff[i]} + 1'b1) >> 1;
      wrap[i]      = bus.ch_en[i] & (cnt_q[i] == (n_eff[i] - ONE_F));
      shadow_nx[i] = bus.div_upd[i] ? bus.div_factor[i*DIV_WID +: DIV_WID] : shadow_q[i];
      apply[i]     = (pend_q[i] | bus.div_upd[i]) & (bus.align | ~bus.ch_en[i] | wrap[i]);
      cnt_nx[i]    = wrap[i] ? '0 : cnt_q[i] + ONE_F;
      lvl_nx[i]    = ({1'b0, cnt_nx[i]} < half[i]);
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cnt_q[i]    <= '0;
        cur_q[i]    <= DEF_F;
        shadow_q[i] <= '0;
      end
      pend_q <= '0;
      en_q   <= '0;
      div_q  <= '0;
      ack_q  <= '0;
    end else begin
      ack_q  <= apply;
      pend_q <= (pend_q | bus.div_upd) & ~apply;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        shadow_q[i] <= shadow_nx[i];
        if (apply[i]) begin
          cur_q[i] <= shadow_nx[i];
        end
        if (bus.align || !bus.ch_en[i]) begin
          cnt_q[i] <= '0;
          en_q[i]  <= 1'b0;
          div_q[i] <= 1'b0;
        end else begin
          cnt_q[i] <= cnt_nx[i];
          en_q[i]  <= wrap[i];
          div_q[i] <= lvl_nx[i];
        end
      end
    end
  end

  always_comb begin
    cur_flat = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cur_flat[i*DIV_WID +: DIV_WID] = cur_q[i];
    end
  end

  assign bus.div_ack = ack_q;
  assign bus.div_cur = cur_flat;
  assign bus.clk_en  = en_q;
  assign bus.clk_div = div_q;

endmodule

// File: tb/tb_apb_clk_en_div_multi.sv
// Randomized scoreboard bench for apb_clk_en_div_multi against a period-arithmetic model.
module tb_apb_clk_en_div_multi;

  localparam int DW  = 4;
  localparam int CN  = 4;
  localparam int DEF = 1;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  apb_clk_en_div_multi_if #(.DIV_WID(DW), .CH_NUM(CN)) bus ();

  apb_clk_en_div_multi #(.DIV_WID(DW), .CH_NUM(CN), .DEF_DIV(DEF)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  typedef struct {
    logic [CN-1:0]    en;
    logic [CN-1:0]    dv;
    logic [CN-1:0]    ack;
    logic [CN*DW-1:0] cur;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: raw active factor, shadow, pending flag, edges since period origin.
  int m_cur[CN];
  int m_sh[CN];
  int m_t[CN];
  bit m_pend[CN];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CN; c++) begin
      m_cur[c]  = DEF;
      m_sh[c]   = 0;
      m_t[c]    = 0;
      m_pend[c] = 1'b0;
    end
  endtask

  // Predict outputs after the coming posedge from the inputs now driven.
  task automatic model_step();
    exp_t e;
    int   n, ph, sh;
    bit   pe, wr, ap;
    e.en = '0; e.dv = '0; e.ack = '0; e.cur = '0;
    for (int c = 0; c < CN; c++) begin
      n  = (m_cur[c] == 0) ? 1 : m_cur[c];
      pe = m_pend[c] | bus.div_upd[c];
      sh = bus.div_upd[c] ? int'(bus.div_factor[c*DW +: DW]) : m_sh[c];
      wr = 1'b0;
      if (bus.align || !bus.ch_en[c]) begin
        m_t[c] = 0;
      end else begin
        m_t[c]   = m_t[c] + 1;
        ph       = m_t[c] % n;
        wr       = (ph == 0);
        e.en[c]  = wr;
        e.dv[c]  = (ph < (n + 1) / 2);
      end
      ap = pe && (bus.align || !bus.ch_en[c] || wr);
      e.ack[c] = ap;
      m_sh[c]  = sh;
      if (ap) begin
        m_cur[c]  = sh;
        m_pend[c] = 1'b0;
        m_t[c]    = 0;
      end else begin
        m_pend[c] = pe;
      end
      e.cur[c*DW +: DW] = DW'(m_cur[c]);
    end
    sb.push_back(e);
  endtask

  task automatic randomize_inputs();
    for (int c = 0; c < CN; c++) begin
      if ($urandom_range(39) == 0) bus.ch_en[c] = ~bus.ch_en[c];
      bus.div_upd[c] = ($urandom_range(7) == 0);
    end
    bus.div_factor = 16'($urandom);
    bus.align      = ($urandom_range(31) == 0);
  endtask

  initial begin : monitor
    forever begin
      @(posedge hclk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("clk_en",  64'(bus.clk_en),  64'(mon_e.en));
        check("clk_div", 64'(bus.clk_div), 64'(mon_e.dv));
        check("div_ack", 64'(bus.div_ack), 64'(mon_e.ack));
        check("div_cur", 64'(bus.div_cur), 64'(mon_e.cur));
      end
    end
  end

  initial begin : stim
    hreset         = 1'b1;
    bus.ch_en      = 4'b0001;
    bus.div_factor = '0;
    bus.div_upd    = '0;
    bus.align      = 1'b0;
    #12;
    check("rst_clk_en",  64'(bus.clk_en),  64'h0);
    check("rst_clk_div", 64'(bus.clk_div), 64'h0);
    check("rst_div_ack", 64'(bus.div_ack), 64'h0);
    check("rst_div_cur", 64'(bus.div_cur), 64'h1111);
    model_reset();

    @(negedge hclk);
    hreset = 1'b0;
    model_step();
    repeat (8) begin
      @(negedge hclk);
      model_step();
    end

    @(negedge hclk);
    bus.ch_en = '1;
    model_step();
    for (int k = 0; k < 3000; k++) begin
      @(negedge hclk);
      if (k == 1500) begin
        // Leave updates pending on every channel, then reset mid-period.
        bus.div_upd    = '1;
        bus.div_factor = 16'hFEDC;
        bus.align      = 1'b0;
        model_step();
        @(negedge hclk);
        bus.div_upd = '0;
        #2;
        hreset = 1'b1;
        #1;
        check("arst_clk_en",  64'(bus.clk_en),  64'h0);
        check("arst_clk_div", 64'(bus.clk_div), 64'h0);
        check("arst_div_ack", 64'(bus.div_ack), 64'h0);
        check("arst_div_cur", 64'(bus.div_cur), 64'h1111);
        model_reset();
        @(negedge hclk);
        hreset = 1'b0;
        model_step();
      end else begin
        randomize_inputs();
        model_step();
      end
    end

    @(negedge hclk);
    bus.div_upd = '0;
    bus.align   = 1'b0;
    repeat (3) @(negedge hclk);
    if (sb.size() != 0) check("sb_drain", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
